audio_frame_sequencer: RTL

AUDIO_FRAME_SEQUENCER -- requirements
Module: audio_frame_sequencer

---
 rtl/audio_frame_sequencer_pkg.sv | 21 ++
 rtl/audio_ch_select.sv | 23 ++
 rtl/audio_frame_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/audio_frame_sequencer_pkg.sv
// Shared types and constants for the audio frame sequencer.
// Holds the controller state encoding and the overrun counter helpers.
package audio_frame_sequencer_pkg;

    localparam int unsigned OVR_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_INIT,
        ST_WAIT,
        ST_PROCESS,
        ST_OUTPUT,
        ST_LOAD
    } afs_state_e;

    // Saturating increment for the dropped-frame counter
    function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
        return (&v) ? v : v + OVR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/audio_ch_select.sv
// Per-channel DAC sample selection: mute, raw (captured) or processed sample.
module audio_ch_select
    import audio_frame_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              mute_i,
    input  logic              use_raw_i,
    input  logic [DATA_W-1:0] raw_i,
    input  logic [DATA_W-1:0] proc_i,
    output logic [DATA_W-1:0] sample_o_c
);

    always_comb begin
        sample_o_c = proc_i;
        if (mute_i) begin
            sample_o_c = '0;
        end else if (use_raw_i) begin
            sample_o_c = raw_i;
        end
    end

endmodule

// File: rtl/audio_frame_sequencer.sv
// Audio frame sequencer: codec init, ADC frame capture, optional DSP round trip,
// per-channel DAC output selection and coefficient load handshake.
module audio_frame_sequencer
    import audio_frame_sequencer_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                       Clk,
    input  logic                       Reset,
    output logic                       init_req,
    input  logic                       init_done,
    input  logic                       frame_valid,
    input  logic [NUM_CH*DATA_W-1:0]   adc_data,
    input  logic                       dsp_enable,
    input  logic [NUM_CH-1:0]          ch_bypass,
    input  logic [NUM_CH-1:0]          ch_mute,
    output logic                       dsp_start,
    output logic [NUM_CH*DATA_W-1:0]   dsp_in,
    input  logic                       dsp_done,
    input  logic [NUM_CH*DATA_W-1:0]   dsp_out,
    output logic [NUM_CH*DATA_W-1:0]   dac_data,
    output logic                       dac_valid,
    input  logic                       load_req,
    output logic                       coef_push,
    input  logic                       coef_ack,
    output logic                       coef_updated,
    output logic [OVR_CNT_W-1:0]       overrun_cnt,
    output logic                       dsp_timeout
);

    localparam int unsigned FRAME_W = NUM_CH * DATA_W;
    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

    afs_state_e           state_q;
    logic [FRAME_W-1:0]   frame_q;
    logic [FRAME_W-1:0]   proc_q;
    logic                 proc_ok_q;
    logic                 pend_q;
    logic [TMO_W-1:0]     tmo_cnt_q;
    logic [OVR_CNT_W-1:0] ovr_cnt_q;
    logic                 dsp_timeout_q;
    logic                 init_req_q;
    logic                 dsp_start_q;
    logic [FRAME_W-1:0]   dac_data_q;
    logic                 dac_valid_q;
    logic                 coef_push_q;
    logic                 coef_upd_q;

    logic [NUM_CH-1:0]    use_raw_d;
    logic [FRAME_W-1:0]   dac_sel_d;

    // Raw sample is used unless a DSP result arrived for this frame
    assign use_raw_d = ch_bypass | {NUM_CH{~proc_ok_q}} | {NUM_CH{~dsp_enable}};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        audio_ch_select #(
            .DATA_W(DATA_W)
        ) u_ch_select (
            .mute_i     (ch_mute[g]),
            .use_raw_i  (use_raw_d[g]),
            .raw_i      (frame_q[g*DATA_W +: DATA_W]),
            .proc_i     (proc_q[g*DATA_W +: DATA_W]),
            .sample_o_c (dac_sel_d[g*DATA_W +: DATA_W])
        );
    end

    // Controller: state, datapath registers and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_RESET;
            frame_q       <= '0;
            proc_q        <= '0;
            proc_ok_q     <= 1'b0;
            pend_q        <= 1'b0;
            tmo_cnt_q     <= '0;
            ovr_cnt_q     <= '0;
            dsp_timeout_q <= 1'b0;
            init_req_q    <= 1'b0;
            dsp_start_q   <= 1'b0;
            dac_data_q    <= '0;
            dac_valid_q   <= 1'b0;
            coef_push_q   <= 1'b0;
            coef_upd_q    <= 1'b0;
        end else begin
            init_req_q  <= 1'b0;
            dsp_start_q <= 1'b0;
            dac_valid_q <= 1'b0;
            coef_upd_q  <= 1'b0;

            if (load_req) begin
                pend_q <= 1'b1;
            end
            if (frame_valid && (state_q != ST_WAIT)) begin
                ovr_cnt_q <= sat_inc(ovr_cnt_q);
            end

            case (state_q)
                ST_RESET: begin
                    state_q    <= ST_INIT;
                    init_req_q <= 1'b1;
                end
                ST_INIT: begin
                    if (init_done) begin
                        state_q <= ST_WAIT;
                    end else begin
                        init_req_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (frame_valid) begin
                        frame_q   <= adc_data;
                        proc_ok_q <= 1'b0;
                        tmo_cnt_q <= '0;
                        if (dsp_enable) begin
                            state_q     <= ST_PROCESS;
                            dsp_start_q <= 1'b1;
                        end else begin
                            state_q <= ST_OUTPUT;
                        end
                    end else if (pend_q) begin
                        state_q     <= ST_LOAD;
                        coef_push_q <= 1'b1;
                    end
                end
                ST_PROCESS: begin
                    if (dsp_done) begin
                        proc_q    <= dsp_out;
                        proc_ok_q <= 1'b1;
                        state_q   <= ST_OUTPUT;
                    end else if (tmo_cnt_q == TMO_W'(TIMEOUT)) begin
                        dsp_timeout_q <= 1'b1;
                        state_q       <= ST_OUTPUT;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    dac_data_q  <= dac_sel_d;
                    dac_valid_q <= 1'b1;
                    if (pend_q) begin
                        state_q     <= ST_LOAD;
                        coef_push_q <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_LOAD: begin
                    if (coef_ack) begin
                        coef_push_q <= 1'b0;
                        coef_upd_q  <= 1'b1;
                        pend_q      <= load_req;
                        state_q     <= ST_WAIT;
                    end
                end
                default: begin
                    state_q <= ST_RESET;
                end
            endcase
        end
    end

    assign init_req     = init_req_q;
    assign dsp_start    = dsp_start_q;
    assign dsp_in       = frame_q;
    assign dac_data     = dac_data_q;
    assign dac_valid    = dac_valid_q;
    assign coef_push    = coef_push_q;
    assign coef_updated = coef_upd_q;
    assign overrun_cnt  = ovr_cnt_q;
    assign dsp_timeout  = dsp_timeout_q;

endmodule
